// File: rtl/serial_cmd_decoder_marine_radar_if.sv
// Host serial link and register-bus signals of the marine radar command decoder.
// The master side is the host/readback mux; the slave side is the decoder.
interface serial_cmd_decoder_marine_radar_if;
    logic        serial_enable;
    logic        serial_clock;
    logic        serial_data_in;
    logic        serial_data_out;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic [6:0]  readback_addr;
    logic [31:0] readback_data;
    logic        frame_error;

    modport master (
        output serial_enable, serial_clock, serial_data_in, readback_data,
        input  serial_data_out, serial_addr, serial_data, serial_strobe,
               readback_addr, frame_error
    );

    modport slave (
        input  serial_enable, serial_clock, serial_data_in, readback_data,
        output serial_data_out, serial_addr, serial_data, serial_strobe,
               readback_addr, frame_error
    );
endinterface

// File: rtl/serial_cmd_decoder_marine_radar.sv
// Serial command decoder: 40-bit frames (R/W, 7-bit address, 32-bit data) from an async host.
// Define SERIAL_READBACK_EN to compile in the read path (readback_addr / shift-out on serial_data_out).
module serial_cmd_decoder_marine_radar (
    input  logic master_clk,
    input  logic reset,
    serial_cmd_decoder_marine_radar_if.slave bus
);

`ifdef SERIAL_READBACK_EN
    typedef enum logic [2:0] {IDLE, HDR, WDATA, RLOAD, RDATA} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, WDATA} state_t;
`endif

    state_t      state, state_next;
    logic [1:0]  en_sync, sclk_sync, sdi_sync;
    logic        en_d, sclk_d;
    logic        en_s, sclk_s, sdi_s;
    logic        en_rise, en_fall, bit_tick;
    logic [5:0]  bit_cnt;
    logic        rw;
    logic [38:0] frame_sr;
    logic [6:0]  addr_q;
    logic [31:0] data_q;
    logic        strobe_q, error_q;

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            en_sync   <= 2'b00;
            sclk_sync <= 2'b00;
            sdi_sync  <= 2'b00;
            en_d      <= 1'b0;
            sclk_d    <= 1'b0;
        end else begin
            en_sync   <= {en_sync[0], bus.serial_enable};
            sclk_sync <= {sclk_sync[0], bus.serial_clock};
            sdi_sync  <= {sdi_sync[0], bus.serial_data_in};
            en_d      <= en_sync[1];
            sclk_d    <= sclk_sync[1];
        end
    end

    assign en_s     = en_sync[1];
    assign sclk_s   = sclk_sync[1];
    assign sdi_s    = sdi_sync[1];
    assign en_rise  = en_s & ~en_d;
    assign en_fall  = ~en_s & en_d;
    assign bit_tick = sclk_s & ~sclk_d & en_s;

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Enable edges take priority over any serial clock edge seen in the same cycle.
    always_comb begin
        state_next = state;
        if (en_rise) begin
            state_next = HDR;
        end else if (en_fall) begin
            state_next = IDLE;
        end else begin
            case (state)
                HDR: begin
                    if (bit_tick && bit_cnt == 6'd7) begin
`ifdef SERIAL_READBACK_EN
                        state_next = rw ? RLOAD : WDATA;
`else
                        state_next = WDATA;
`endif
                    end
                end
`ifdef SERIAL_READBACK_EN
                RLOAD:   state_next = RDATA;
`endif
                default: state_next = state;
            endcase
        end
    end

    // Frame capture and completion; a frame is valid only with exactly 40 bits at enable fall.
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= 6'd0;
            rw       <= 1'b0;
            frame_sr <= 39'd0;
            addr_q   <= 7'd0;
            data_q   <= 32'd0;
            strobe_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            error_q  <= 1'b0;
            if (en_rise) begin
                bit_cnt <= 6'd0;
            end else if (en_fall) begin
                if (state != IDLE) begin
                    if (bit_cnt == 6'd40) begin
                        if (!rw) begin
                            addr_q   <= frame_sr[38:32];
                            data_q   <= frame_sr[31:0];
                            strobe_q <= 1'b1;
                        end
                    end else begin
                        error_q <= 1'b1;
                    end
                end
            end else if (bit_tick && state != IDLE) begin
                if (bit_cnt != 6'd41) bit_cnt <= bit_cnt + 6'd1;
                if (bit_cnt == 6'd0)       rw       <= sdi_s;
                else if (bit_cnt < 6'd40)  frame_sr <= {frame_sr[37:0], sdi_s};
            end
        end
    end

    assign bus.serial_addr   = addr_q;
    assign bus.serial_data   = data_q;
    assign bus.serial_strobe = strobe_q;
    assign bus.frame_error   = error_q;

`ifdef SERIAL_READBACK_EN
    logic [31:0] rd_sr;
    logic [6:0]  rb_addr;
    logic        sclk_fall;

    assign sclk_fall = ~sclk_s & sclk_d;

    // The mux sees rb_addr during RLOAD, so its answer is captured on the way out of RLOAD.
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            rd_sr   <= 32'd0;
            rb_addr <= 7'd0;
        end else begin
            if (state == HDR && state_next == RLOAD)
                rb_addr <= {frame_sr[5:0], sdi_s};
            if (state == RLOAD)
                rd_sr <= bus.readback_data;
            else if (state == RDATA && state_next == RDATA && sclk_fall)
                rd_sr <= {rd_sr[30:0], 1'b0};
        end
    end

    assign bus.readback_addr   = rb_addr;
    assign bus.serial_data_out = (state == RDATA) ? rd_sr[31] : 1'b0;
`else
    logic unused_readback;

    assign unused_readback     = ^bus.readback_data;
    assign bus.readback_addr   = 7'd0;
    assign bus.serial_data_out = 1'b0;
`endif

endmodule

// File: tb/tb_serial_cmd_decoder_marine_radar.sv
// Directed bench for serial_cmd_decoder_marine_radar: writes, truncated frames, reads,
// mid-frame reset and an enable fall coincident with a clock edge.
module tb_serial_cmd_decoder_marine_radar;

    localparam int HALF = 10;

    logic master_clk = 1'b0;
    logic reset;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   strobe_cnt   = 0;
    int   error_cnt    = 0;
    int   dout_hi_cnt  = 0;

    serial_cmd_decoder_marine_radar_if bus ();

    serial_cmd_decoder_marine_radar dut (
        .master_clk (master_clk),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 master_clk = ~master_clk;

    // Pulse monitors sample on the falling edge, away from the active edge.
    always @(negedge master_clk) begin
        if (bus.serial_strobe)   strobe_cnt  <= strobe_cnt + 1;
        if (bus.frame_error)     error_cnt   <= error_cnt + 1;
        if (bus.serial_data_out) dout_hi_cnt <= dout_hi_cnt + 1;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [39:0] actual, input logic [39:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic start_frame();
        @(negedge master_clk);
        bus.serial_clock  = 1'b0;
        bus.serial_enable = 1'b1;
        repeat (HALF) @(negedge master_clk);
    endtask

    task automatic send_bits(input logic [39:0] frame, input int nbits, output logic [31:0] rd_word);
        rd_word = 32'd0;
        for (int i = 0; i < nbits; i++) begin
            bus.serial_data_in = frame[39-i];
            repeat (HALF) @(negedge master_clk);
            bus.serial_clock = 1'b1;
            repeat (HALF) @(negedge master_clk);
            if (i >= 7 && i <= 38) rd_word[38-i] = bus.serial_data_out;
            bus.serial_clock = 1'b0;
        end
    endtask

    task automatic end_frame(input bit on_edge);
        repeat (HALF) @(negedge master_clk);
        if (on_edge) bus.serial_clock = 1'b1;
        bus.serial_enable = 1'b0;
        repeat (HALF) @(negedge master_clk);
        bus.serial_clock = 1'b0;
        repeat (2 * HALF) @(negedge master_clk);
    endtask

    task automatic apply_stimulus(input logic [39:0] frame, input int nbits, input bit on_edge,
                                  output logic [31:0] rd_word);
        start_frame();
        send_bits(frame, nbits, rd_word);
        end_frame(on_edge);
    endtask

    initial begin
        logic [31:0] rd_word;
        logic [31:0] exp_rd_word;
        logic [6:0]  exp_rb_addr;
        int          s0, e0, d0;

        reset              = 1'b1;
        bus.serial_enable  = 1'b0;
        bus.serial_clock   = 1'b0;
        bus.serial_data_in = 1'b0;
        bus.readback_data  = 32'hDEAD_BEEF;
        repeat (5) @(negedge master_clk);

        check_output("rst_addr",   {33'd0, bus.serial_addr},     40'd0);
        check_output("rst_data",   {8'd0, bus.serial_data},      40'd0);
        check_output("rst_strobe", {39'd0, bus.serial_strobe},   40'd0);
        check_output("rst_rbaddr", {33'd0, bus.readback_addr},   40'd0);
        check_output("rst_dout",   {39'd0, bus.serial_data_out}, 40'd0);
        check_output("rst_ferr",   {39'd0, bus.frame_error},     40'd0);
        reset = 1'b0;
        repeat (5) @(negedge master_clk);

        s0 = strobe_cnt; e0 = error_cnt;
        apply_stimulus({1'b0, 7'h05, 32'h0000_0190}, 40, 1'b0, rd_word);
        check_output("wr1_strobes", 40'(strobe_cnt - s0), 40'd1);
        check_output("wr1_errors",  40'(error_cnt - e0),  40'd0);
        check_output("wr1_addr",    {33'd0, bus.serial_addr}, 40'h05);
        check_output("wr1_data",    {8'd0, bus.serial_data},  40'h0000_0190);

        s0 = strobe_cnt; e0 = error_cnt;
        apply_stimulus({1'b0, 7'h7F, 32'hA5A5_5A5A}, 40, 1'b0, rd_word);
        check_output("wr2_strobes", 40'(strobe_cnt - s0), 40'd1);
        check_output("wr2_addr",    {33'd0, bus.serial_addr}, 40'h7F);
        check_output("wr2_data",    {8'd0, bus.serial_data},  40'hA5A5_5A5A);

        s0 = strobe_cnt; e0 = error_cnt;
        apply_stimulus({1'b0, 7'h11, 32'h1234_5678}, 39, 1'b0, rd_word);
        check_output("trunc_errors",  40'(error_cnt - e0),  40'd1);
        check_output("trunc_strobes", 40'(strobe_cnt - s0), 40'd0);
        check_output("trunc_addr",    {33'd0, bus.serial_addr}, 40'h7F);
        check_output("trunc_data",    {8'd0, bus.serial_data},  40'hA5A5_5A5A);

`ifdef SERIAL_READBACK_EN
        exp_rd_word = 32'hDEAD_BEEF;
        exp_rb_addr = 7'h20;
`else
        exp_rd_word = 32'd0;
        exp_rb_addr = 7'd0;
`endif
        s0 = strobe_cnt; e0 = error_cnt; d0 = dout_hi_cnt;
        apply_stimulus({1'b1, 7'h20, 32'h0000_0000}, 40, 1'b0, rd_word);
        check_output("rd_word",    {8'd0, rd_word},               {8'd0, exp_rd_word});
        check_output("rd_rbaddr",  {33'd0, bus.readback_addr},    {33'd0, exp_rb_addr});
        check_output("rd_strobes", 40'(strobe_cnt - s0),          40'd0);
        check_output("rd_errors",  40'(error_cnt - e0),           40'd0);
        check_output("rd_idle_dout", {39'd0, bus.serial_data_out}, 40'd0);
`ifndef SERIAL_READBACK_EN
        check_output("rd_dout_high", 40'(dout_hi_cnt - d0), 40'd0);
`endif

        s0 = strobe_cnt; e0 = error_cnt;
        apply_stimulus({1'b1, 7'h20, 32'h0000_0000}, 20, 1'b0, rd_word);
        check_output("rdshort_errors",  40'(error_cnt - e0),  40'd1);
        check_output("rdshort_strobes", 40'(strobe_cnt - s0), 40'd0);

        s0 = strobe_cnt; e0 = error_cnt;
        start_frame();
        send_bits({1'b0, 7'h55, 32'hFFFF_FFFF}, 20, rd_word);
        @(negedge master_clk);
        reset             = 1'b1;
        bus.serial_enable = 1'b0;
        bus.serial_clock  = 1'b0;
        repeat (5) @(negedge master_clk);
        reset = 1'b0;
        repeat (2 * HALF) @(negedge master_clk);
        check_output("rstmid_strobes", 40'(strobe_cnt - s0), 40'd0);
        check_output("rstmid_errors",  40'(error_cnt - e0),  40'd0);
        check_output("rstmid_addr",    {33'd0, bus.serial_addr}, 40'd0);
        apply_stimulus({1'b0, 7'h07, 32'h0000_0001}, 40, 1'b0, rd_word);
        check_output("rstwr_strobes", 40'(strobe_cnt - s0), 40'd1);
        check_output("rstwr_addr",    {33'd0, bus.serial_addr}, 40'h07);
        check_output("rstwr_data",    {8'd0, bus.serial_data},  40'h1);

        s0 = strobe_cnt; e0 = error_cnt;
        apply_stimulus({1'b0, 7'h33, 32'hC0FF_EE01}, 40, 1'b1, rd_word);
        check_output("coin_strobes", 40'(strobe_cnt - s0), 40'd1);
        check_output("coin_errors",  40'(error_cnt - e0),  40'd0);
        check_output("coin_count",   {34'd0, dut.bit_cnt},     40'd40);
        check_output("coin_addr",    {33'd0, bus.serial_addr}, 40'h33);
        check_output("coin_data",    {8'd0, bus.serial_data},  40'hC0FF_EE01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
